// File: rtl/menu_screen_mux_if.sv
// Bundle between the menu screen drawers, the screen-change controller and the video priority mux.
interface menu_screen_mux_if #(
    parameter int unsigned N_SCREENS = 4,
    parameter int unsigned SEL_W     = 2
) ();
    logic                   startOfFrame;
    logic                   sel_valid;
    logic [SEL_W-1:0]       sel_req;
    logic [N_SCREENS-1:0]   drawingRequestIn;
    logic [8*N_SCREENS-1:0] RGBIn;
    logic                   drawingRequestOut;
    logic [7:0]             RGBOut;
    logic [SEL_W-1:0]       active_sel;
    logic                   busy;

    modport master (
        output startOfFrame, sel_valid, sel_req, drawingRequestIn, RGBIn,
        input  drawingRequestOut, RGBOut, active_sel, busy
    );

    modport slave (
        input  startOfFrame, sel_valid, sel_req, drawingRequestIn, RGBIn,
        output drawingRequestOut, RGBOut, active_sel, busy
    );
endinterface

// File: rtl/menu_screen_mux.sv
// Frame-synchronous N-way menu screen selector with an optional blank transition
// of programmable length and a one-cycle registered RGB/drawing-request pipeline.
module menu_screen_mux #(
    parameter int unsigned N_SCREENS    = 4,
    parameter int unsigned SEL_W        = 2,
    parameter int unsigned INIT_SEL     = 0,
    parameter int unsigned TRANS_FRAMES = 2,
    parameter logic [7:0]  BLANK_RGB    = 8'h00
) (
    input logic              clk,
    input logic              resetN,
    menu_screen_mux_if.slave bus
);
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CNT_LOAD = (TRANS_FRAMES > 0) ? TRANS_FRAMES - 1 : 0;

    typedef enum logic [1:0] {IDLE, WAIT_SOF, BLANK} state_t;

    state_t           state;
    logic [SEL_W-1:0] pending_sel;
    logic [CNT_W-1:0] frame_cnt;

    logic             req_ok_c;
    logic [SEL_W-1:0] next_pending_c;
    logic             sel_dr_c;
    logic [7:0]       sel_rgb_c;

    // Out-of-range indices are dropped; a request arriving on the commit cycle still wins.
    assign req_ok_c       = bus.sel_valid && (32'(bus.sel_req) < N_SCREENS);
    assign next_pending_c = req_ok_c ? bus.sel_req : pending_sel;

    // Channel select for the currently committed screen.
    always_comb begin
        sel_dr_c  = 1'b0;
        sel_rgb_c = 8'h00;
        for (int i = 0; i < int'(N_SCREENS); i++) begin
            if (bus.active_sel == SEL_W'(i)) begin
                sel_dr_c  = bus.drawingRequestIn[i];
                sel_rgb_c = bus.RGBIn[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state                 <= IDLE;
            pending_sel           <= SEL_W'(INIT_SEL);
            frame_cnt             <= '0;
            bus.active_sel        <= SEL_W'(INIT_SEL);
            bus.busy              <= 1'b0;
            bus.drawingRequestOut <= 1'b0;
            bus.RGBOut            <= 8'h00;
        end else begin
            // Output pipeline follows the state held before this edge.
            if (state == BLANK) begin
                bus.drawingRequestOut <= 1'b1;
                bus.RGBOut            <= BLANK_RGB;
            end else begin
                bus.drawingRequestOut <= sel_dr_c;
                bus.RGBOut            <= sel_rgb_c;
            end

            case (state)
                IDLE: begin
                    // startOfFrame is deliberately not consumed here.
                    if (req_ok_c && (bus.sel_req != bus.active_sel)) begin
                        pending_sel <= bus.sel_req;
                        bus.busy    <= 1'b1;
                        state       <= WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    pending_sel <= next_pending_c;
                    if (bus.startOfFrame) begin
                        if (TRANS_FRAMES == 0) begin
                            bus.active_sel <= next_pending_c;
                            bus.busy       <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            frame_cnt <= CNT_W'(CNT_LOAD);
                            state     <= BLANK;
                        end
                    end
                end
                BLANK: begin
                    pending_sel <= next_pending_c;
                    if (bus.startOfFrame) begin
                        if (frame_cnt == '0) begin
                            bus.active_sel <= next_pending_c;
                            bus.busy       <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            frame_cnt <= frame_cnt - CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
